// File: rtl/gate_vec_pkg.sv
// Shared types and field widths for the gate-vector loader.
package gate_vec_pkg;

  localparam int unsigned A_W   = 8;
  localparam int unsigned O_W   = 15;
  localparam int unsigned VEC_W = 24;
  localparam int unsigned N_BIT = 7;

  typedef enum logic [2:0] {
    StLoad0,
    StLoad1,
    StLoad2,
    StSettle,
    StResp
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/gate_vector_loader.sv
// Assembles a 24-bit gate operand vector from three bytes, applies it, waits a settle
// time, then returns the sampled gate output as a handshaked result.
module gate_vector_loader
  import gate_vec_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [A_W-1:0]   a_vec,
  output logic [O_W-1:0]   o_vec,
  output logic             n_out,
  input  logic             y_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_data,
  output logic [CNT_W-1:0] hit_count
);

  state_e         state_q, state_d;
  logic [7:0]     stage0_q, stage0_d;
  logic [7:0]     stage1_q, stage1_d;
  logic [3:0]     settle_q, settle_d;
  logic [A_W-1:0] a_vec_q;
  logic [O_W-1:0] o_vec_q;
  logic           n_q;
  logic           res_data_q, res_data_d;
  // Holds in_ready low until the first edge after reset release.
  logic           live_q;
  logic           apply;
  logic           sample;
  logic           accept;
  logic           loading;

  assign loading   = (state_q == StLoad0) || (state_q == StLoad1) || (state_q == StLoad2);
  assign in_ready  = live_q && loading;
  assign res_valid = (state_q == StResp);
  assign accept    = in_valid && in_ready && !clear;

  always_comb begin
    state_d    = state_q;
    stage0_d   = stage0_q;
    stage1_d   = stage1_q;
    settle_d   = settle_q;
    res_data_d = res_data_q;
    apply      = 1'b0;
    sample     = 1'b0;
    if (clear) begin
      state_d    = StLoad0;
      stage0_d   = '0;
      stage1_d   = '0;
      res_data_d = 1'b0;
    end else begin
      case (state_q)
        StLoad0: begin
          if (accept) begin
            stage0_d = in_data;
            state_d  = StLoad1;
          end
        end
        StLoad1: begin
          if (accept) begin
            stage1_d = in_data;
            state_d  = StLoad2;
          end
        end
        StLoad2: begin
          if (accept) begin
            apply    = 1'b1;
            settle_d = 4'(SETTLE_CYCLES);
            state_d  = StSettle;
          end
        end
        StSettle: begin
          if (settle_q == 4'd1) begin
            sample     = 1'b1;
            res_data_d = y_in;
            state_d    = StResp;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
        StResp: begin
          if (res_ready) begin
            state_d = StLoad0;
          end
        end
        default: state_d = StLoad0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad0;
      stage0_q   <= '0;
      stage1_q   <= '0;
      settle_q   <= '0;
      res_data_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage0_q   <= stage0_d;
      stage1_q   <= stage1_d;
      settle_q   <= settle_d;
      res_data_q <= res_data_d;
      live_q     <= 1'b1;
    end
  end

  // Byte2 goes straight to the outputs so the whole vector lands on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vec_q <= '0;
      o_vec_q <= '0;
      n_q     <= 1'b0;
    end else if (apply) begin
      a_vec_q <= stage0_q;
      o_vec_q <= {in_data[6:0], stage1_q};
      n_q     <= in_data[N_BIT];
    end
  end

  assign a_vec    = a_vec_q;
  assign o_vec    = o_vec_q;
  assign n_out    = n_q;
  assign res_data = res_data_q;

  sat_counter #(
    .W(CNT_W)
  ) u_hit_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sample && y_in),
    .clr  (clear),
    .count(hit_count)
  );

endmodule

// File: tb/tb_gate_vector_loader.sv
// Self-checking bench: directed scenarios plus randomized vectors against a byte-level model.
module tb_gate_vector_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, in_valid, res_ready;
  logic [7:0]  in_data;
  logic        in_ready, n_out, y_in, res_valid, res_data;
  logic [7:0]  a_vec;
  logic [14:0] o_vec;
  logic [15:0] hit_count;

  logic        clear2, in_valid2, res_ready2;
  logic [7:0]  in_data2;
  logic        in_ready2, n_out2, y_in2, res_valid2, res_data2;
  logic [7:0]  a_vec2;
  logic [14:0] o_vec2;
  logic [1:0]  hit_count2;

  // Gate stage: AND of A, OR of O, NOT of N, all combined by AND.
  assign y_in  = (&a_vec) & (|o_vec) & ~n_out;
  assign y_in2 = (&a_vec2) & (|o_vec2) & ~n_out2;

  gate_vector_loader #(.SETTLE_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .a_vec(a_vec), .o_vec(o_vec), .n_out(n_out), .y_in(y_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .hit_count(hit_count)
  );

  gate_vector_loader #(.SETTLE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .a_vec(a_vec2), .o_vec(o_vec2), .n_out(n_out2), .y_in(y_in2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
    .hit_count(hit_count2)
  );

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;

  function automatic logic ref_y(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2);
    logic [14:0] ors;
    ors = {b2[6:0], b1};
    return (b0 == 8'hFF) && (ors != 15'd0) && !b2[7];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_byte2(input logic [7:0] b);
    int budget = 0;
    while (!in_ready2 && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    if (!in_ready2) begin
      checks++; errors++;
      $display("FAIL send_byte2_timeout: in_ready=%0b required 1", in_ready2);
    end
    in_valid2 = 1'b1; in_data2 = b;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_data = 8'h00;
    clear2 = 1'b0; in_valid2 = 1'b0; res_ready2 = 1'b0; in_data2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, a_vec, o_vec, n_out, res_valid, res_data, hit_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%0b a=%h o=%h n=%0b rv=%0b rd=%0b hc=%0d required all 0",
               in_ready, a_vec, o_vec, n_out, res_valid, res_data, hit_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: in_ready=%0b required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: in_ready=%0b required 1", in_ready);
    end
    exp_hits = 0;
  endtask

  task automatic test_basic_hit();
    send_byte(8'hFF); send_byte(8'h01); send_byte(8'h00);
    checks++;
    if (a_vec !== 8'hFF || o_vec !== 15'h0001 || n_out !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_vector: a=%h o=%h n=%0b rv=%0b required a=ff o=0001 n=0 rv=0",
               a_vec, o_vec, n_out, res_valid);
    end
    @(posedge clk); #1;
    exp_hits++;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 1'b1 || hit_count !== 16'(exp_hits)) begin
      errors++;
      $display("FAIL hit_result: rv=%0b rd=%0b hc=%0d required rv=1 rd=1 hc=%0d",
               res_valid, res_data, hit_count, exp_hits);
    end
    consume();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hit_consume: rv=%0b rdy=%0b required rv=0 rdy=1", res_valid, in_ready);
    end
  endtask

  task automatic test_miss_n();
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'hC0);
    checks++;
    if (o_vec !== 15'h4000 || n_out !== 1'b1) begin
      errors++;
      $display("FAIL miss_vector: o=%h n=%0b required o=4000 n=1", o_vec, n_out);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 1'b0 || hit_count !== 16'(exp_hits)) begin
      errors++;
      $display("FAIL miss_result: rv=%0b rd=%0b hc=%0d required rv=1 rd=0 hc=%0d",
               res_valid, res_data, hit_count, exp_hits);
    end
    consume();
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'hFF); send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, a_vec, o_vec, n_out, res_valid, res_data, hit_count} !== '0) begin
      errors++;
      $display("FAIL midload_reset: rdy=%0b a=%h o=%h n=%0b rv=%0b rd=%0b hc=%0d required 0",
               in_ready, a_vec, o_vec, n_out, res_valid, res_data, hit_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_hits = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midload_ready: in_ready=%0b required 1", in_ready);
    end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00);
    checks++;
    if (a_vec !== 8'hAA || o_vec !== 15'h0001) begin
      errors++;
      $display("FAIL midload_byte0: a=%h o=%h required a=aa o=0001", a_vec, o_vec);
    end
    @(posedge clk); #1;
    consume();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    send_byte(8'hFF); send_byte(8'h01); send_byte(8'h00);
    @(posedge clk); #1;
    exp_hits++;
    in_valid = 1'b1; in_data = 8'h55; res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rv=%0b rd=%0b rdy=%0b required rv=1 rd=1 rdy=0",
                 i, res_valid, res_data, in_ready);
      end
    end
    consume();
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_byte(8'h01); send_byte(8'h00);
    checks++;
    if (a_vec !== 8'h55 || hit_count !== 16'(exp_hits)) begin
      errors++;
      $display("FAIL bp_next_byte0: a=%h hc=%0d required a=55 hc=%0d", a_vec, hit_count,
               exp_hits);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_result: rv=%0b rd=%0b required rv=1 rd=0", res_valid, res_data);
    end
    consume();
  endtask

  task automatic test_clear();
    logic [7:0]  a_old;
    logic [14:0] o_old;
    logic        n_old;
    send_byte(8'h12);
    a_old = a_vec; o_old = o_vec; n_old = n_out;
    in_valid = 1'b1; in_data = 8'h34; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    exp_hits = 0;
    checks++;
    if (in_ready !== 1'b1 || hit_count !== 16'd0 || res_valid !== 1'b0 || res_data !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: rdy=%0b hc=%0d rv=%0b rd=%0b required rdy=1 hc=0 rv=0 rd=0",
               in_ready, hit_count, res_valid, res_data);
    end
    checks++;
    if (a_vec !== a_old || o_vec !== o_old || n_out !== n_old) begin
      errors++;
      $display("FAIL clear_vec_held: a=%h o=%h n=%0b required a=%h o=%h n=%0b",
               a_vec, o_vec, n_out, a_old, o_old, n_old);
    end
    send_byte(8'h77); send_byte(8'h01); send_byte(8'h00);
    checks++;
    if (a_vec !== 8'h77 || o_vec !== 15'h0001) begin
      errors++;
      $display("FAIL clear_restart: a=%h o=%h required a=77 o=0001", a_vec, o_vec);
    end
    @(posedge clk); #1;
    consume();
  endtask

  task automatic test_random();
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp_vec;
    logic        exp_y;
    for (int k = 0; k < 30; k++) begin
      b0 = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      b2 = 8'($urandom) & (($urandom_range(0, 1) == 1) ? 8'h7F : 8'hFF);
      exp_vec = {b0, b2[6:0], b1, b2[7]};
      exp_y = ref_y(b0, b1, b2);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_byte(b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_byte(b1);
      send_byte(b2);
      checks++;
      if ({a_vec, o_vec, n_out} !== exp_vec) begin
        errors++;
        $display("FAIL rand_vec[%0d]: got=%h required=%h", k, {a_vec, o_vec, n_out}, exp_vec);
      end
      @(posedge clk); #1;
      if (exp_y) exp_hits++;
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_y || hit_count !== 16'(exp_hits)) begin
        errors++;
        $display("FAIL rand_res[%0d]: rv=%0b rd=%0b hc=%0d required rv=1 rd=%0b hc=%0d",
                 k, res_valid, res_data, hit_count, exp_y, exp_hits);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      consume();
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    for (int k = 1; k <= 4; k++) begin
      send_byte2(8'hFF); send_byte2(8'h01); send_byte2(8'h00);
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        checks++;
        if (res_valid2 !== 1'b0) begin
          errors++;
          $display("FAIL sat_early[%0d/%0d]: rv=%0b required 0", k, c, res_valid2);
        end
      end
      @(posedge clk); #1;
      exp_cnt = (k < 3) ? k : 3;
      checks++;
      if (res_valid2 !== 1'b1 || res_data2 !== 1'b1 || hit_count2 !== 2'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_result[%0d]: rv=%0b rd=%0b hc=%0d required rv=1 rd=1 hc=%0d",
                 k, res_valid2, res_data2, hit_count2, exp_cnt);
      end
      res_ready2 = 1'b1;
      @(posedge clk); #1;
      res_ready2 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_miss_n();
    test_reset_mid_load();
    test_backpressure();
    test_clear();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_vector_loader.md
# gate_vector_loader

Byte-serial front end for the multi-input gate-logic stage. It assembles a 24-bit operand vector (8 AND inputs, 15 OR inputs, 1 NOT input) from three handshaked bytes and drives it onto the gate stage's inputs. After a programmable settle time it samples the gate stage's single output and returns it as a handshaked result, keeping a saturating count of vectors that produced 1.

## Interface
- SETTLE_CYCLES, 1: cycles from vector apply to Y sample; legal range 1..15.
- CNT_W, 16: width of hit counter.

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous soft clear
- in_valid  in  1  byte available
- in_ready  out  1  loader accepts byte
- in_data  in  8  operand byte
- a_vec  out  8  AND inputs; bit0 = A1 … bit7 = A8
- o_vec  out  15  OR inputs; bit0 = O1 … bit14 = O15
- n_out  out  1  NOT input
- y_in  in  1  gate stage output
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  1  sampled Y
- hit_count  out  CNT_W  count of results with Y = 1, saturating

## Operation
- Byte mapping, in order:
  - byte0 → A8..A1.
  - byte1 → O8..O1.
  - byte2[6:0] → O15..O9; byte2[7] → N.
- States:
  - LOAD0, LOAD1, LOAD2: in_ready = 1. Each accepted byte (in_valid & in_ready) goes to staging and advances the state.
  - SETTLE: in_ready = 0. Down-counter loaded with SETTLE_CYCLES.
  - RESP: res_valid = 1.
- Transitions:
  - LOAD2 accept → SETTLE. On that same edge, the full staged vector (byte2 direct) copies into a_vec/o_vec/n_out. Outputs never change mid-load.
  - SETTLE, counter = 1 → RESP. On that edge res_data ← y_in and hit_count increments if y_in = 1 (saturates at all-ones).
  - RESP with res_ready → LOAD0.
- a_vec/o_vec/n_out hold the last applied vector until the next LOAD2 accept.
- clear (synchronous, highest priority):
  - Forces state to LOAD0; drops staged bytes and any pending result; zeroes hit_count and res_data.
  - Vector outputs are held, not cleared.
  - A handshake coincident with clear is ignored: no byte consumed, no result consumed.
- rst_n low (asynchronous, any state including mid-load or mid-settle): all state returns to reset values. Partial vectors are discarded.

## Timing
- Reset values:
  - in_ready = 0; it rises on the first clk edge after rst_n deassertion (state LOAD0).
  - a_vec = 0, o_vec = 0, n_out = 0.
  - res_valid = 0, res_data = 0, hit_count = 0.
- Back-to-back bytes: one per cycle. Minimum load = 3 cycles.
- Latency: the last byte accepted at edge T applies the vector at T. Y is sampled at edge T + SETTLE_CYCLES, and res_valid is high from that edge.
- res_valid/res_data are stable until the cycle res_ready is seen high. Consumption at edge R means in_ready = 1 from R.
- Throughput with res_ready tied high and SETTLE_CYCLES = 1: one vector per 5 cycles.
- in_valid while in_ready = 0 is ignored; in_data is not consumed.
- hit_count at all-ones stays all-ones on further hits.

## Structure
- Shared package gate_vec_pkg:
  - state enum (LOAD0, LOAD1, LOAD2, SETTLE, RESP);
  - localparams A_W = 8, O_W = 15, VEC_W = 24, N_BIT = 7 (position in byte2).
- One sub-module: sat_counter (parameter W; inc, clr inputs; count output; async active-low reset). Used for hit_count.
- Everything else stays in gate_vector_loader: FSM, staging, settle counter, output registers.

## Test plan
- Reset mid-load:
  - Stimulus: send 0xFF, 0x00, then assert rst_n low for 2 cycles.
  - Required: all outputs return to their reset values immediately. After release, in_ready = 1 after one edge, and the next byte is treated as byte0.
- Basic hit, SETTLE_CYCLES = 1, with the gate stage connected:
  - Stimulus: bytes 0xFF, 0x01, 0x00.
  - Required: a_vec = 0xFF, o_vec = 0x0001, n_out = 0. res_valid is asserted 1 cycle after the third byte, with res_data = 1 and hit_count = 1.
- Miss via N:
  - Stimulus: bytes 0xFF, 0x00, 0xC0.
  - Required: o_vec = 0x4000 (O15), n_out = 1, res_data = 0, hit_count unchanged.
- Backpressure:
  - Stimulus: res_ready held low for 10 cycles, with in_valid held high carrying 0x55.
  - Required: res_valid and res_data stable; in_ready = 0; no byte consumed. When res_ready is raised, the next accepted byte is 0x55 as byte0.
- Clear vs. handshake:
  - Stimulus: clear asserted in the same cycle as a LOAD1 accept.
  - Required: byte not consumed, state LOAD0, hit_count = 0, vector outputs unchanged.
- Settle and saturation, SETTLE_CYCLES = 4, CNT_W = 2:
  - Stimulus: 4 hitting vectors.
  - Required: each result appears exactly 4 cycles after its third byte. hit_count reads 1, 2, 3, 3.
